sum_accum: RTL

Downstream consumer for the 5-bit ripple adder. It captures each {carry-out, sum} result offered by the adder stage under a valid/ready handshake. It accumulates a fixed number of these results into a wider register, then presents the block total with a sticky overflow flag on an output valid/ready handshake. It sits directly after the adder and before any result checker or logger.

---
 rtl/sum_accum_if.sv | 38 +++
 rtl/sum_accum.sv | 100 ++++++++++
 2 files changed

// File: rtl/sum_accum_if.sv
// sum_accum_if: handshake bundle between the adder stage, the block
// accumulator and the downstream consumer of block totals.
//
//   clr        producer -> accum   synchronous abort of the current block
//   in_valid   producer -> accum   adder result present
//   in_ready   accum -> producer   accumulator can take a sample this cycle
//   in_sum     producer -> accum   adder sum bits (DATA_W)
//   in_co      producer -> accum   adder carry-out
//   out_valid  accum -> consumer   block total available
//   out_ready  consumer -> accum   consumer takes the total
//   out_acc    accum -> consumer   saturated block total (ACC_W)
//   out_ovf    accum -> consumer   total saturated during the block
//
// master is the side driving samples/clr/out_ready; slave is the accumulator.
interface sum_accum_if #(
    parameter int DATA_W = 5,
    parameter int ACC_W  = 10
) ();
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_sum;
    logic              in_co;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;

    modport master (
        output clr, in_valid, in_sum, in_co, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  clr, in_valid, in_sum, in_co, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/sum_accum.sv
// sum_accum: accumulates COUNT adder results ({carry-out, sum}) into a
// saturating ACC_W-bit total, then offers the total with a sticky overflow
// flag on an output valid/ready handshake.
//
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (priority over clr)
//   bus    sum_accum_if.slave: clr, in_valid/in_ready/in_sum/in_co,
//          out_valid/out_ready/out_acc/out_ovf
module sum_accum #(
    parameter int DATA_W = 5,
    parameter int ACC_W  = 10,
    parameter int COUNT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sum_accum_if.slave  bus
);
    typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

    localparam logic [7:0] LAST = 8'(COUNT - 1);

    state_t            state;
    state_t            state_nx;
    logic [ACC_W-1:0]  acc;
    logic [7:0]        cnt;
    logic              ovf;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;
    logic [ACC_W-1:0]  sample;
    logic [ACC_W:0]    add_res;
    logic              accept;
    logic              last;

    // Returns {overflow, value}; the value pins to all ones on overflow,
    // so an all-ones accumulator stays all ones for the rest of the block.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[ACC_W])
            return {1'b1, {ACC_W{1'b1}}};
        return s;
    endfunction

    always_comb begin
        sample            = '0;
        sample[DATA_W:0]  = {bus.in_co, bus.in_sum};
    end

    // in_ready depends on state and rst_n only
    assign bus.in_ready  = rst_n && (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.out_acc   = out_acc;
    assign bus.out_ovf   = out_ovf;

    assign accept  = bus.in_valid && bus.in_ready && !bus.clr;
    assign last    = (cnt == LAST);
    assign add_res = sat_add(acc, sample);

    always_comb begin
        state_nx = state;
        case (state)
            ACCUM: if (accept && last) state_nx = DONE;
            DONE:  if (bus.out_ready)  state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ACCUM;
        else if (bus.clr)
            state <= ACCUM;
        else
            state <= state_nx;
    end

    // Accumulator, count and result registers; clr/reset drop any pending total
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_acc <= '0;
            out_ovf <= 1'b0;
        end else if (accept) begin
            acc <= add_res[ACC_W-1:0];
            cnt <= cnt + 8'd1;
            ovf <= ovf | add_res[ACC_W];
            if (last) begin
                out_acc <= add_res[ACC_W-1:0];
                out_ovf <= ovf | add_res[ACC_W];
            end
        end else if (state == DONE && bus.out_ready) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end
    end
endmodule
